kl10pv_top: RTL and testbench

- Top-level shell of the KL10pv model: owns the front-end diagnostic (EBUS diag) interface and the CLK-board control logic.
- Decodes diagnostic function codes strobed by the front end and drives the EBOX clock enables, EBOX reset and the CLK configuration registers.
- Generates the free-running MHZ16_FREE reference that the front end synchronises its strobes to.
- The EBOX/MBOX datapaths sit behind this block's enable/reset outputs and are out of scope.

---
 rtl/kl10pv_if.sv | 10 +
 rtl/kl10pv_top.sv | 184 ++++++++++++++++++
 tb/tb_kl10pv_top.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kl10pv_if.sv
// KL10pv front-end diagnostic bus: function code, strobe and EBUS data.
// Bit 0 is the MSB on ds and data, matching the PDP-10 bit numbering.
interface kl10pv_if;
    logic [0:6]  ds;
    logic        diagStrobe;
    logic [0:35] data;

    modport master (output ds, output diagStrobe, output data);
    modport slave  (input ds, input diagStrobe, input data);
endinterface

// File: rtl/kl10pv_top.sv
// KL10pv shell: diag function decoder, CLK-board registers,
// EBOX clock state machine and MHZ16_FREE reference divider.
module kl10pv_top #(
    parameter int MHZ16_DIV  = 3,
    parameter int RESET_HOLD = 8
) (
    input  logic        clk,
    input  logic        CROBAR_N,
    kl10pv_if.slave     diag,
    output logic        MHZ16_FREE,
    output logic        EBOX_CLK_EN,
    output logic        EBOX_RESET,
    output logic [1:0]  SOURCE_SEL,
    output logic [1:0]  RATE_SEL,
    output logic [7:0]  BURST_CNT,
    output logic [10:0] CRAM_DIAG_ADR,
    output logic [3:0]  PAR_CHK_EN,
    output logic        KL_OPCODES_EN,
    output logic [0:35] EBUS_REG,
    output logic        RUNNING
);

    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam int DW = (MHZ16_DIV > 1) ? $clog2(MHZ16_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(MHZ16_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(MHZ16_DIV / 2);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_STEP,
        ST_BURST
    } clk_st_t;

    logic [HW-1:0] hold_cnt;
    logic          rst_n;
    logic [DW-1:0] div_cnt;
    logic          mhz_q;
    logic          s_meta;
    logic          s_sync;
    logic          s_prev;
    logic          s_rise;
    logic          pend;
    logic [0:6]    cmd;
    logic [0:35]   cmd_dat;
    logic          ebox_rst;
    logic [7:0]    burst_cnt;
    logic [1:0]    src_sel;
    logic [1:0]    rate_sel;
    logic [3:0]    par_en;
    logic [10:0]   cram_adr;
    logic          kl_op;
    logic [0:35]   ebus;
    clk_st_t       st;
    clk_st_t       st_n;
    logic [7:0]    burst_rem;
    logic [7:0]    burst_rem_n;

    // Internal reset: asserted with the crowbar, released after a hold-off.
    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            hold_cnt <= '0;
            rst_n    <= 1'b0;
        end else if (!rst_n) begin
            hold_cnt <= hold_cnt + 1'b1;
            rst_n    <= (hold_cnt == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            mhz_q   <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            mhz_q   <= (div_cnt < DIV_HALF);
        end
    end

    assign s_rise = s_sync & ~s_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta  <= 1'b0;
            s_sync  <= 1'b0;
            s_prev  <= 1'b0;
            pend    <= 1'b0;
            cmd     <= '0;
            cmd_dat <= '0;
        end else begin
            s_meta <= diag.diagStrobe;
            s_sync <= s_meta;
            s_prev <= s_sync;
            pend   <= s_rise;
            if (s_rise) begin
                cmd     <= diag.ds;
                cmd_dat <= diag.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ebox_rst  <= 1'b1;
            burst_cnt <= '0;
            src_sel   <= '0;
            rate_sel  <= '0;
            par_en    <= '0;
            cram_adr  <= '0;
            kl_op     <= 1'b0;
            ebus      <= '0;
        end else if (pend) begin
            unique case (cmd)
                7'o006: ebox_rst <= 1'b0;
                7'o007: ebox_rst <= 1'b1;
                7'o042: burst_cnt[3:0] <= cmd_dat[32:35];
                7'o043: burst_cnt[7:4] <= cmd_dat[32:35];
                7'o044: begin
                    src_sel  <= cmd_dat[32:33];
                    rate_sel <= cmd_dat[34:35];
                end
                7'o046: par_en <= cmd_dat[32:35];
                7'o051: cram_adr[4:0] <= cmd_dat[31:35];
                7'o052: cram_adr[10:5] <= cmd_dat[30:35];
                7'o067: kl_op <= cmd_dat[35];
                7'o076: ebus <= cmd_dat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_STOP;
            burst_rem <= '0;
        end else begin
            st        <= st_n;
            burst_rem <= burst_rem_n;
        end
    end

    // Clock commands override the free-running STEP/BURST progression.
    always_comb begin
        st_n        = st;
        burst_rem_n = burst_rem;
        unique case (st)
            ST_STOP: ;
            ST_RUN:  ;
            ST_STEP: st_n = ST_STOP;
            ST_BURST: begin
                burst_rem_n = burst_rem - 8'd1;
                if (burst_rem <= 8'd1) st_n = ST_STOP;
            end
        endcase
        if (pend) begin
            unique case (cmd)
                7'o000: st_n = ST_STOP;
                7'o001: st_n = ST_RUN;
                7'o002: st_n = ST_STEP;
                7'o003: st_n = ST_STEP;
                7'o004: if (!ebox_rst) st_n = ST_STEP;
                7'o005: begin
                    burst_rem_n = burst_cnt;
                    st_n = (burst_cnt == 8'd0) ? ST_STOP : ST_BURST;
                end
                default: ;
            endcase
        end
    end

    assign MHZ16_FREE    = mhz_q;
    assign EBOX_CLK_EN   = (st != ST_STOP);
    assign RUNNING       = (st == ST_RUN) || (st == ST_BURST);
    assign EBOX_RESET    = ebox_rst;
    assign SOURCE_SEL    = src_sel;
    assign RATE_SEL      = rate_sel;
    assign BURST_CNT     = burst_cnt;
    assign CRAM_DIAG_ADR = cram_adr;
    assign PAR_CHK_EN    = par_en;
    assign KL_OPCODES_EN = kl_op;
    assign EBUS_REG      = ebus;

endmodule

// File: tb/tb_kl10pv_top.sv
// Bench for kl10pv_top: directed diag strobes, a function-level model
// compared every cycle, and literal checks that pin the model.
module tb_kl10pv_top;

    localparam int DIV  = 3;
    localparam int HOLD = 8;

    logic        clk;
    logic        CROBAR_N;
    logic        MHZ16_FREE;
    logic        EBOX_CLK_EN;
    logic        EBOX_RESET;
    logic [1:0]  SOURCE_SEL;
    logic [1:0]  RATE_SEL;
    logic [7:0]  BURST_CNT;
    logic [10:0] CRAM_DIAG_ADR;
    logic [3:0]  PAR_CHK_EN;
    logic        KL_OPCODES_EN;
    logic [0:35] EBUS_REG;
    logic        RUNNING;

    kl10pv_if dif ();

    kl10pv_top #(.MHZ16_DIV(DIV), .RESET_HOLD(HOLD)) dut (
        .clk           (clk),
        .CROBAR_N      (CROBAR_N),
        .diag          (dif),
        .MHZ16_FREE    (MHZ16_FREE),
        .EBOX_CLK_EN   (EBOX_CLK_EN),
        .EBOX_RESET    (EBOX_RESET),
        .SOURCE_SEL    (SOURCE_SEL),
        .RATE_SEL      (RATE_SEL),
        .BURST_CNT     (BURST_CNT),
        .CRAM_DIAG_ADR (CRAM_DIAG_ADR),
        .PAR_CHK_EN    (PAR_CHK_EN),
        .KL_OPCODES_EN (KL_OPCODES_EN),
        .EBUS_REG      (EBUS_REG),
        .RUNNING       (RUNNING)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int         at;
        logic [6:0] code;
        logic [35:0] v;
    } cmd_t;

    cmd_t q[$];
    int   cyc = 0;

    // Function-level model: registers, run flag and pulses still owed.
    int          m_hold = HOLD;
    int          m_ph = 0;
    bit          m_run = 0;
    int          m_left = 0;
    bit          m_isb = 0;
    logic        m_erst = 1'b1;
    logic [7:0]  m_bcnt = '0;
    logic [1:0]  m_src = '0;
    logic [1:0]  m_rate = '0;
    logic [3:0]  m_par = '0;
    logic [10:0] m_cram = '0;
    logic        m_kl = 1'b0;
    logic [35:0] m_ebus = '0;

    task automatic mreset();
        m_hold = HOLD;
        m_ph = 0;
        m_run = 0;
        m_left = 0;
        m_isb = 0;
        m_erst = 1'b1;
        m_bcnt = '0;
        m_src = '0;
        m_rate = '0;
        m_par = '0;
        m_cram = '0;
        m_kl = 1'b0;
        m_ebus = '0;
        q.delete();
    endtask

    task automatic apply(input cmd_t c);
        case (c.code)
            7'o000: begin m_run = 0; m_left = 0; end
            7'o001: begin m_run = 1; m_left = 0; end
            7'o002, 7'o003: begin m_run = 0; m_left = 1; m_isb = 0; end
            7'o004: if (!m_erst) begin m_run = 0; m_left = 1; m_isb = 0; end
            7'o005: begin m_run = 0; m_left = int'(m_bcnt); m_isb = 1; end
            7'o006: m_erst = 1'b0;
            7'o007: m_erst = 1'b1;
            7'o042: m_bcnt[3:0] = c.v[3:0];
            7'o043: m_bcnt[7:4] = c.v[3:0];
            7'o044: begin m_src = c.v[3:2]; m_rate = c.v[1:0]; end
            7'o046: m_par = c.v[3:0];
            7'o051: m_cram[4:0] = c.v[4:0];
            7'o052: m_cram[10:5] = c.v[5:0];
            7'o067: m_kl = c.v[0];
            7'o076: m_ebus = c.v;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!CROBAR_N) begin
            mreset();
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            m_ph++;
            if (m_left > 0) m_left--;
            if (q.size() > 0 && q[0].at == cyc) apply(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!CROBAR_N || m_hold > 0) begin
            chk("rst_ebox_reset", 64'(EBOX_RESET), 64'd1);
            chk("rst_clk_en", 64'(EBOX_CLK_EN), 64'd0);
            chk("rst_mhz", 64'(MHZ16_FREE), 64'd0);
            chk("rst_regs", 64'({BURST_CNT, SOURCE_SEL, RATE_SEL, PAR_CHK_EN,
                CRAM_DIAG_ADR, KL_OPCODES_EN, RUNNING}), 64'd0);
            chk("rst_ebus", 64'(EBUS_REG), 64'd0);
        end else begin
            chk("mhz", 64'(MHZ16_FREE), 64'(m_ph > 0 &&
                ((m_ph - 1) % DIV) < (DIV / 2)));
            chk("clk_en", 64'(EBOX_CLK_EN), 64'(m_run || m_left > 0));
            chk("running", 64'(RUNNING), 64'(m_run || (m_left > 0 && m_isb)));
            chk("ebox_reset", 64'(EBOX_RESET), 64'(m_erst));
            chk("burst_cnt", 64'(BURST_CNT), 64'(m_bcnt));
            chk("src_rate", 64'({SOURCE_SEL, RATE_SEL}), 64'({m_src, m_rate}));
            chk("par_en", 64'(PAR_CHK_EN), 64'(m_par));
            chk("cram_adr", 64'(CRAM_DIAG_ADR), 64'(m_cram));
            chk("kl_op", 64'(KL_OPCODES_EN), 64'(m_kl));
            chk("ebus", 64'(EBUS_REG), 64'(m_ebus));
        end
    end

    int en_cnt = 0;
    always @(negedge clk) if (EBOX_CLK_EN === 1'b1) en_cnt++;

    task automatic strobe(input logic [6:0] code, input logic [35:0] v,
                          input int hold);
        @(negedge clk);
        dif.ds = code;
        dif.data = v;
        dif.diagStrobe = 1'b1;
        q.push_back('{cyc + 4, code, v});
        repeat (hold) @(negedge clk);
        dif.diagStrobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    int c0;
    int k;

    initial begin
        dif.ds = '0;
        dif.data = '0;
        dif.diagStrobe = 1'b0;
        CROBAR_N = 1'b1;
        #2 CROBAR_N = 1'b0;
        repeat (10) @(negedge clk);
        chk("lit_reset_ebox_reset", 64'(EBOX_RESET), 64'd1);
        chk("lit_reset_clk_en", 64'(EBOX_CLK_EN), 64'd0);
        repeat (40) @(negedge clk);
        CROBAR_N = 1'b1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (MHZ16_FREE === 1'b1) begin k = i; break; end
        end
        chk("lit_mhz_first_high", 64'(k), 64'(HOLD + 1));

        // Master reset sequence, each strobe held 3 MHZ16 periods.
        strobe(7'o007, 36'd0, 3 * DIV);
        strobe(7'o006, 36'd0, 3 * DIV);
        strobe(7'o000, 36'd0, 3 * DIV);
        strobe(7'o044, 36'd0, 3 * DIV);
        strobe(7'o046, 36'o13, 3 * DIV);
        strobe(7'o042, 36'd3, 3 * DIV);
        strobe(7'o043, 36'd9, 3 * DIV);
        strobe(7'o051, 36'h15, 3 * DIV);
        strobe(7'o052, 36'h2a, 3 * DIV);
        strobe(7'o067, 36'd1, 3 * DIV);
        strobe(7'o076, 36'o123456701234, 3 * DIV);
        chk("lit_master_ebox_reset", 64'(EBOX_RESET), 64'd0);
        chk("lit_master_kl_op", 64'(KL_OPCODES_EN), 64'd1);
        chk("lit_master_ebus", 64'(EBUS_REG), 64'o123456701234);
        chk("lit_master_cram", 64'(CRAM_DIAG_ADR), 64'h555);
        chk("lit_master_par", 64'(PAR_CHK_EN), 64'hb);
        chk("lit_master_bcnt", 64'(BURST_CNT), 64'h93);

        strobe(7'o044, 36'd6, 3);
        chk("lit_src_rate", 64'({SOURCE_SEL, RATE_SEL}), 64'b0110);
        strobe(7'o077, 36'o777777777777, 3);

        c0 = en_cnt;
        strobe(7'o002, 36'd0, 3 * DIV);
        chk("lit_step_held_once", 64'(en_cnt - c0), 64'd1);

        strobe(7'o001, 36'd0, 3);
        repeat (20) @(negedge clk);
        chk("lit_start_en", 64'(EBOX_CLK_EN), 64'd1);
        strobe(7'o000, 36'd0, 3);
        chk("lit_stop_en", 64'(EBOX_CLK_EN), 64'd0);

        strobe(7'o042, 36'd5, 3);
        strobe(7'o043, 36'd0, 3);
        c0 = en_cnt;
        strobe(7'o005, 36'd0, 3);
        repeat (5) @(negedge clk);
        chk("lit_burst_pulses", 64'(en_cnt - c0), 64'd5);
        chk("lit_burst_cnt_kept", 64'(BURST_CNT), 64'h05);

        strobe(7'o042, 36'd0, 3);
        c0 = en_cnt;
        strobe(7'o005, 36'd0, 3);
        repeat (5) @(negedge clk);
        chk("lit_burst_zero", 64'(en_cnt - c0), 64'd0);

        strobe(7'o042, 36'd15, 3);
        strobe(7'o005, 36'd0, 3);
        strobe(7'o001, 36'd0, 3);
        repeat (30) @(negedge clk);
        chk("lit_start_in_burst", 64'(RUNNING), 64'd1);
        strobe(7'o000, 36'd0, 3);

        strobe(7'o007, 36'd0, 3);
        c0 = en_cnt;
        strobe(7'o004, 36'd0, 3);
        repeat (5) @(negedge clk);
        chk("lit_cond_ss_blocked", 64'(en_cnt - c0), 64'd0);
        strobe(7'o006, 36'd0, 3);
        c0 = en_cnt;
        strobe(7'o004, 36'd0, 3);
        repeat (5) @(negedge clk);
        chk("lit_cond_ss_pulse", 64'(en_cnt - c0), 64'd1);

        // Crowbar in the middle of a 200-cycle burst.
        strobe(7'o042, 36'd8, 3);
        strobe(7'o043, 36'd12, 3);
        @(negedge clk);
        dif.ds = 7'o005;
        dif.data = '0;
        dif.diagStrobe = 1'b1;
        q.push_back('{cyc + 4, 7'o005, 36'd0});
        repeat (4) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("lit_abort_pre_en", 64'(EBOX_CLK_EN), 64'd1);
        CROBAR_N = 1'b0;
        #1;
        chk("lit_abort_en", 64'(EBOX_CLK_EN), 64'd0);
        chk("lit_abort_bcnt", 64'(BURST_CNT), 64'd0);
        chk("lit_abort_ebox_reset", 64'(EBOX_RESET), 64'd1);
        dif.diagStrobe = 1'b0;
        repeat (20) @(negedge clk);
        CROBAR_N = 1'b1;
        repeat (30) @(negedge clk);
        chk("lit_after_abort_en", 64'(EBOX_CLK_EN), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
